// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare/select opcodes, operand classes and the
// canonical quiet NaN. Class encoding is chosen so that numeric order of the
// enum matches value order (N < Z < P).
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_FEQ  = 3'd0,
        OP_FLT  = 3'd1,
        OP_FLE  = 3'd2,
        OP_FMIN = 3'd3,
        OP_FMAX = 3'd4
    } fcmp_op_e;

    typedef enum logic [1:0] {
        CLS_N = 2'd0,
        CLS_Z = 2'd1,
        CLS_P = 2'd2
    } fclass_e;

    localparam logic [31:0] FCMP_CANON_NAN = 32'h7FC0_0000;

    // Every exponent-zero encoding (both zeros and all subnormals) counts as zero.
    function automatic fclass_e fclass_of(input logic [31:0] x);
        if (x[30:23] == 8'h00) begin
            return CLS_Z;
        end else if (x[31]) begin
            return CLS_N;
        end else begin
            return CLS_P;
        end
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fcmp_classify.sv
// Combinational operand classifier feeding the S1 registers of fcmp_pipe.
// Produces both operand classes plus the 31-bit magnitude compare.
// With FCMP_NAN_EN defined it also flags NaN operands.
module fcmp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output fclass_e     c1,
    output fclass_e     c2,
    output logic        mag_lt,
    output logic        mag_eq
`ifdef FCMP_NAN_EN
    ,
    output logic        nan1,
    output logic        nan2
`endif
);

    assign c1     = fclass_of(x1);
    assign c2     = fclass_of(x2);
    assign mag_lt = x1[30:0] < x2[30:0];
    assign mag_eq = x1[30:0] == x2[30:0];

`ifdef FCMP_NAN_EN
    assign nan1 = is_nan(x1);
    assign nan2 = is_nan(x2);
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage handshaked floating-point compare/select (FEQ/FLT/FLE/FMIN/FMAX).
// S1 holds operands, classes and magnitude compare; S2 holds the result.
// in_ready depends combinationally on out_ready so a full pipe can pop and
// push in the same cycle. Define FCMP_NAN_EN to enable NaN handling.
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    // Same-class ordering: negatives compare by reversed magnitude, zeros never less.
    function automatic logic less_than(input fclass_e c1, input fclass_e c2,
                                       input logic mlt, input logic meq);
        if (c1 != c2) begin
            return c1 < c2;
        end
        case (c1)
            CLS_P:   return mlt;
            CLS_N:   return !mlt && !meq;
            default: return 1'b0;
        endcase
    endfunction

    fclass_e cls1, cls2;
    logic    mag_lt, mag_eq;

    // S1 state
    logic             s1_v_q, s1_v_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [31:0]      s1_x1_q, s1_x1_d;
    logic [31:0]      s1_x2_q, s1_x2_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    fclass_e          s1_c1_q, s1_c1_d;
    fclass_e          s1_c2_q, s1_c2_d;
    logic             s1_mlt_q, s1_mlt_d;
    logic             s1_meq_q, s1_meq_d;

    // S2 state
    logic             s2_v_q, s2_v_d;
    logic [31:0]      s2_y_q, s2_y_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_ill_q, s2_ill_d;

    logic        s1_adv, s2_adv;
    logic        eq, lt, le, both_z;
    logic [31:0] res_y;
    logic        res_ill;

`ifdef FCMP_NAN_EN
    logic nan1, nan2;
    logic s1_nan1_q, s1_nan1_d;
    logic s1_nan2_q, s1_nan2_d;
`endif

    fcmp_classify u_classify (
        .x1     (in_x1),
        .x2     (in_x2),
        .c1     (cls1),
        .c2     (cls2),
        .mag_lt (mag_lt),
        .mag_eq (mag_eq)
`ifdef FCMP_NAN_EN
        ,
        .nan1   (nan1),
        .nan2   (nan2)
`endif
    );

    // Handshake, result selection from S1, and next-state for both stages.
    always_comb begin
        s2_adv = !s2_v_q || out_ready;
        s1_adv = !s1_v_q || s2_adv;

        eq     = (s1_c1_q == s1_c2_q) && ((s1_c1_q == CLS_Z) || s1_meq_q);
        lt     = less_than(s1_c1_q, s1_c2_q, s1_mlt_q, s1_meq_q);
        le     = lt || eq;
        both_z = (s1_c1_q == CLS_Z) && (s1_c2_q == CLS_Z);

        res_y   = 32'd0;
        res_ill = 1'b0;
        case (s1_op_q)
            OP_FEQ:  res_y = {31'd0, eq};
            OP_FLT:  res_y = {31'd0, lt};
            OP_FLE:  res_y = {31'd0, le};
            OP_FMIN: res_y = (both_z || le)  ? s1_x1_q : s1_x2_q;
            OP_FMAX: res_y = (both_z || !le) ? s1_x1_q : s1_x2_q;
            default: res_ill = 1'b1;
        endcase

`ifdef FCMP_NAN_EN
        // Any NaN makes the flags false; min/max prefer the non-NaN operand.
        if (s1_nan1_q || s1_nan2_q) begin
            case (s1_op_q)
                OP_FEQ, OP_FLT, OP_FLE: res_y = 32'd0;
                OP_FMIN, OP_FMAX: begin
                    if (s1_nan1_q && s1_nan2_q) begin
                        res_y = FCMP_CANON_NAN;
                    end else if (s1_nan1_q) begin
                        res_y = s1_x2_q;
                    end else begin
                        res_y = s1_x1_q;
                    end
                end
                default: res_y = 32'd0;
            endcase
        end
`endif

        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_x1_d  = s1_x1_q;
        s1_x2_d  = s1_x2_q;
        s1_tag_d = s1_tag_q;
        s1_c1_d  = s1_c1_q;
        s1_c2_d  = s1_c2_q;
        s1_mlt_d = s1_mlt_q;
        s1_meq_d = s1_meq_q;
`ifdef FCMP_NAN_EN
        s1_nan1_d = s1_nan1_q;
        s1_nan2_d = s1_nan2_q;
`endif
        s2_v_d   = s2_v_q;
        s2_y_d   = s2_y_q;
        s2_tag_d = s2_tag_q;
        s2_ill_d = s2_ill_q;

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_y_d   = res_y;
                s2_tag_d = s1_tag_q;
                s2_ill_d = res_ill;
            end
        end

        if (s1_adv) begin
            s1_v_d   = in_valid;
            s1_op_d  = in_op;
            s1_x1_d  = in_x1;
            s1_x2_d  = in_x2;
            s1_tag_d = in_tag;
            s1_c1_d  = cls1;
            s1_c2_d  = cls2;
            s1_mlt_d = mag_lt;
            s1_meq_d = mag_eq;
`ifdef FCMP_NAN_EN
            s1_nan1_d = nan1;
            s1_nan2_d = nan2;
`endif
        end
    end

    // Valid flags and visible outputs; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_y_q   <= 32'd0;
            s2_tag_q <= '0;
            s2_ill_q <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            s2_y_q   <= s2_y_d;
            s2_tag_q <= s2_tag_d;
            s2_ill_q <= s2_ill_d;
        end
    end

    // S1 payload; qualified by s1_v_q so it needs no reset.
    always_ff @(posedge clk) begin
        s1_op_q  <= s1_op_d;
        s1_x1_q  <= s1_x1_d;
        s1_x2_q  <= s1_x2_d;
        s1_tag_q <= s1_tag_d;
        s1_c1_q  <= s1_c1_d;
        s1_c2_q  <= s1_c2_d;
        s1_mlt_q <= s1_mlt_d;
        s1_meq_q <= s1_meq_d;
`ifdef FCMP_NAN_EN
        s1_nan1_q <= s1_nan1_d;
        s1_nan2_q <= s1_nan2_d;
`endif
    end

    assign in_ready    = s1_adv;
    assign out_valid   = s2_v_q;
    assign out_y       = s2_y_q;
    assign out_tag     = s2_tag_q;
    assign out_illegal = s2_ill_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: directed cases plus randomized traffic with
// random backpressure, checked against a value-ordering reference model.
module tb_fcmp_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_x1, in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_x1       (in_x1),
        .in_x2       (in_x2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: map each operand onto a signed integer number line
    // (all exponent-zero values collapse to 0) and compare with plain arithmetic.
    function automatic longint key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        if (x[30:23] == 8'h00) return 0;
        return x[31] ? -m : m;
    endfunction

    function automatic logic nan_of(input logic [31:0] x);
`ifdef FCMP_NAN_EN
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
`else
        return (x == 32'h0) && (x != 32'h0);
`endif
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] t);
        exp_t   e;
        longint ka, kb;
        logic   na, nb, zz;
        ka = key(a);
        kb = key(b);
        na = nan_of(a);
        nb = nan_of(b);
        zz = (a[30:23] == 8'h00) && (b[30:23] == 8'h00);
        e.tag = t;
        e.ill = 1'b0;
        e.y   = 32'h0;
        case (op)
            3'd0: e.y = (!na && !nb && ka == kb) ? 32'd1 : 32'd0;
            3'd1: e.y = (!na && !nb && ka <  kb) ? 32'd1 : 32'd0;
            3'd2: e.y = (!na && !nb && ka <= kb) ? 32'd1 : 32'd0;
            3'd3, 3'd4: begin
                if (na && nb)      e.y = 32'h7FC00000;
                else if (na)       e.y = b;
                else if (nb)       e.y = a;
                else if (zz)       e.y = a;
                else if (op == 3'd3) e.y = (ka <= kb) ? a : b;
                else               e.y = (ka <= kb) ? b : a;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Offer one request; push the expected response at the accepting edge.
    task automatic send_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, input logic [31:0] ey, input logic eill);
        exp_t e;
        int   guard;
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_tag   = t;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            wait_cycles++;
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.y   = ey;
            e.tag = t;
            e.ill = eill;
            sb.push_back(e);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t);
        exp_t e;
        e = model(op, a, b, t);
        send_exp(op, a, b, t, e.y, e.ill);
    endtask

    function automatic logic [31:0] gen_opnd(input logic [31:0] other);
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return {s, 8'h00, 23'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
            2:       return {~other[31], other[30:0]};
            3:       return other;
            4:       return {s, 8'hFF, 23'($urandom_range(0, 1) == 0 ? 0 : $urandom)};
            default: return {s, other[30:23], 23'($urandom)};
        endcase
    endfunction

    // Monitor: pop and compare on every handshake; hold outputs steady while stalled.
    logic             stall_hold = 1'b0;
    logic [31:0]      hold_y;
    logic [TAG_W-1:0] hold_tag;
    logic             hold_ill;

    always @(negedge clk) begin
        if (rst) begin
            stall_hold = 1'b0;
        end else begin
            if (stall_hold) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_y", out_y, hold_y);
                chk("stall_tag", 32'(out_tag), 32'(hold_tag));
                chk("stall_illegal", {31'd0, out_illegal}, {31'd0, hold_ill});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_y", out_y, e.y);
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
            stall_hold = out_valid && !out_ready;
            hold_y     = out_y;
            hold_tag   = out_tag;
            hold_ill   = out_illegal;
        end
    end

    initial begin
        logic [31:0] a, b;
        bit          done;
        int          guard;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_x1     = 32'h0;
        in_x2     = 32'h0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // FEQ of -0 vs subnormal, with latency check
        send_exp(3'd0, 32'h80000000, 32'h00000001, 5'd3, 32'd1, 1'b0);
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_y", out_y, 32'd1);
        chk("lat_tag", 32'(out_tag), 32'd3);
        repeat (3) @(posedge clk);
        #1;

        // FLT streaming at full rate
        wait_cycles = 0;
        send_exp(3'd1, 32'hC0000000, 32'h3F800000, 5'd1, 32'd1, 1'b0);
        send_exp(3'd1, 32'h3F800000, 32'hC0000000, 5'd2, 32'd0, 1'b0);
        send_exp(3'd1, 32'hBF800000, 32'hC0000000, 5'd4, 32'd0, 1'b0);
        chk("stream_no_stall", 32'(wait_cycles), 32'd0);

        // FMIN / FMAX around zero
        send_exp(3'd3, 32'h40400000, 32'h80000000, 5'd5, 32'h80000000, 1'b0);
        send_exp(3'd4, 32'h00000000, 32'h80000000, 5'd6, 32'h00000000, 1'b0);

        // Illegal opcode
        send_exp(3'd6, 32'h3F800000, 32'h3F800000, 5'd7, 32'h0, 1'b0 | 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: 4 stalled cycles while 3 requests are offered
        out_ready = 1'b0;
        fork
            begin
                send_exp(3'd2, 32'h3F800000, 32'h40000000, 5'd10, 32'd1, 1'b0);
                send_exp(3'd2, 32'h40000000, 32'h3F800000, 5'd11, 32'd0, 1'b0);
                send_exp(3'd3, 32'hC0000000, 32'h40000000, 5'd12, 32'hC0000000, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                @(negedge clk);
                chk("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Reset with both stages full: contents must vanish
        out_ready = 1'b0;
        send_exp(3'd0, 32'h3F800000, 32'h3F800000, 5'd20, 32'd1, 1'b0);
        send_exp(3'd0, 32'h3F800000, 32'h40000000, 5'd21, 32'd0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

`ifdef FCMP_NAN_EN
        send_exp(3'd0, 32'h7FC00000, 32'h7FC00000, 5'd8, 32'd0, 1'b0);
        send_exp(3'd3, 32'h7FC00000, 32'h40000000, 5'd9, 32'h40000000, 1'b0);
        send_exp(3'd4, 32'h7FC00001, 32'hFFC00000, 5'd13, 32'h7FC00000, 1'b0);
`endif

        // Randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    a = $urandom;
                    a = gen_opnd(a);
                    b = gen_opnd(a);
                    if ($urandom_range(0, 1) == 1) begin
                        send(3'($urandom_range(0, 7)), a, b, TAG_W'(i));
                    end else begin
                        send(3'($urandom_range(0, 7)), b, a, TAG_W'(i));
                    end
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
